// File: rtl/cache_dummy_xlat.sv
`default_nettype none
// ============================================================================
//  Module   : cache_dummy_xlat
//  Brief    : Multi-channel dummy address-translation stage for cache unit
//             benches. Each channel holds one translation at a time and
//             supports identity, offset and fault-window modes. The response
//             latency is configurable, and the stage keeps saturating
//             completion counters.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_dummy_xlat #(
  parameter int NumChan    = 2,
  parameter int VAddrWidth = 39,
  parameter int PAddrWidth = 56,
  parameter int Latency    = 1,
  parameter int CntWidth   = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [1:0]                      mode_i,
  input  logic [PAddrWidth-1:0]           offset_i,
  input  logic [VAddrWidth-1:0]           fault_base_i,
  input  logic [VAddrWidth-1:0]           fault_mask_i,
  input  logic                            flush_i,
  input  logic [NumChan-1:0]              req_valid_i,
  input  logic [NumChan*VAddrWidth-1:0]   req_vaddr_i,
  output logic [NumChan-1:0]              req_ready_o,
  output logic [NumChan-1:0]              rsp_valid_o,
  output logic [NumChan*PAddrWidth-1:0]   rsp_paddr_o,
  output logic [NumChan-1:0]              rsp_fault_o,
  input  logic [NumChan-1:0]              rsp_ready_i,
  output logic                            busy_o,
  output logic [CntWidth-1:0]             xlat_cnt_o,
  output logic [CntWidth-1:0]             fault_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Countdown reload: WAIT spends Latency-1 cycles, so the counter starts
  // at Latency-2 and RESP is entered on the cycle after it reads zero.
  localparam logic [3:0]          c_lat_load = (Latency >= 2) ? 4'(Latency - 2) : 4'd0;
  localparam logic [CntWidth-1:0] c_cnt_max  = {CntWidth{1'b1}};

  logic [NumChan-1:0] w_rsp_hs;
  logic [NumChan-1:0] w_busy_vec;

  // ------------------------------------------------------------------------
  // Per-channel translation datapath and FSM
  // ------------------------------------------------------------------------
  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_valid;
    logic                  r_fault;
    logic [PAddrWidth-1:0] r_paddr;

    logic [VAddrWidth-1:0] w_vaddr;
    logic [PAddrWidth-1:0] w_vaddr_ext;
    logic [PAddrWidth-1:0] w_paddr;
    logic                  w_fault;
    logic                  w_accept;

    assign w_vaddr = req_vaddr_i[c*VAddrWidth +: VAddrWidth];

    // Compute the translated address from the mode inputs seen this cycle
    always_comb begin
      w_vaddr_ext                 = '0;
      w_vaddr_ext[VAddrWidth-1:0] = w_vaddr;
      w_paddr                     = w_vaddr_ext;
      w_fault                     = 1'b0;
      case (mode_i)
        2'b01: w_paddr = w_vaddr_ext + offset_i;
        2'b10: begin
          if (((w_vaddr ^ fault_base_i) & fault_mask_i) == '0) begin
            w_fault = 1'b1;
            w_paddr = '0;
          end
        end
        default: ;
      endcase
    end

    // Flush and reset both block acceptance, so nothing can slip in while
    // the channel is being torn down.
    assign req_ready_o[c] = (r_state == ST_IDLE) & ~flush_i & ~rst_i;
    assign w_accept       = req_valid_i[c] & req_ready_o[c];
    assign w_rsp_hs[c]    = r_valid & rsp_ready_i[c];
    assign w_busy_vec[c]  = (r_state != ST_IDLE);

    assign rsp_valid_o[c]                          = r_valid;
    assign rsp_fault_o[c]                          = r_fault;
    assign rsp_paddr_o[c*PAddrWidth +: PAddrWidth] = r_paddr;

    // Channel FSM: IDLE -> WAIT -> RESP -> IDLE, with registered response outputs
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
        r_valid <= 1'b0;
        r_fault <= 1'b0;
        r_paddr <= '0;
      end else if (flush_i) begin
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_paddr <= w_paddr;
              r_fault <= w_fault;
              if (Latency <= 1) begin
                r_state <= ST_RESP;
                r_valid <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
                r_cnt   <= c_lat_load;
              end
            end
          end
          ST_WAIT: begin
            if (r_cnt == 4'd0) begin
              r_state <= ST_RESP;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          ST_RESP: begin
            if (rsp_ready_i[c]) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o = |w_busy_vec;

  // ------------------------------------------------------------------------
  // Statistics counters
  // ------------------------------------------------------------------------
  logic [3:0]            w_hs_num;
  logic [3:0]            w_fault_num;
  logic [CntWidth+3:0]   w_xlat_sum;
  logic [CntWidth+3:0]   w_fault_sum;
  logic [CntWidth-1:0]   r_xlat_cnt;
  logic [CntWidth-1:0]   r_fault_cnt;

  // Count this cycle's handshakes and widen sums so saturation is detectable
  always_comb begin
    w_hs_num    = 4'd0;
    w_fault_num = 4'd0;
    for (int i = 0; i < NumChan; i++) begin
      w_hs_num    = w_hs_num + {3'b000, w_rsp_hs[i]};
      w_fault_num = w_fault_num + {3'b000, w_rsp_hs[i] & rsp_fault_o[i]};
    end
    w_xlat_sum  = {4'b0000, r_xlat_cnt}  + {{CntWidth{1'b0}}, w_hs_num};
    w_fault_sum = {4'b0000, r_fault_cnt} + {{CntWidth{1'b0}}, w_fault_num};
  end

  // Saturating counters; handshakes in a flush cycle still count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xlat_cnt  <= '0;
      r_fault_cnt <= '0;
    end else begin
      r_xlat_cnt  <= (w_xlat_sum  > {4'b0000, c_cnt_max}) ? c_cnt_max : w_xlat_sum[CntWidth-1:0];
      r_fault_cnt <= (w_fault_sum > {4'b0000, c_cnt_max}) ? c_cnt_max : w_fault_sum[CntWidth-1:0];
    end
  end

  assign xlat_cnt_o  = r_xlat_cnt;
  assign fault_cnt_o = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_dummy_xlat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_dummy_xlat
//  Brief    : Bench for cache_dummy_xlat. It applies directed scenarios and
//             randomized traffic, and compares every cycle against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_dummy_xlat;

  localparam int NC  = 2;
  localparam int VA  = 39;
  localparam int PA  = 56;
  localparam int LAT = 3;
  localparam int CW  = 9;
  localparam int MAX = (1 << CW) - 1;

  logic               clk;
  logic               rst;
  logic [1:0]         mode;
  logic [PA-1:0]      offset;
  logic [VA-1:0]      fbase;
  logic [VA-1:0]      fmask;
  logic               flush;
  logic [NC-1:0]      req_valid;
  logic [NC*VA-1:0]   req_vaddr;
  logic [NC-1:0]      req_ready;
  logic [NC-1:0]      rsp_valid;
  logic [NC*PA-1:0]   rsp_paddr;
  logic [NC-1:0]      rsp_fault;
  logic [NC-1:0]      rsp_ready;
  logic               busy;
  logic [CW-1:0]      xlat_cnt;
  logic [CW-1:0]      fault_cnt;

  cache_dummy_xlat #(
    .NumChan(NC), .VAddrWidth(VA), .PAddrWidth(PA), .Latency(LAT), .CntWidth(CW)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .offset_i(offset),
    .fault_base_i(fbase), .fault_mask_i(fmask), .flush_i(flush),
    .req_valid_i(req_valid), .req_vaddr_i(req_vaddr), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_paddr_o(rsp_paddr), .rsp_fault_o(rsp_fault),
    .rsp_ready_i(rsp_ready), .busy_o(busy), .xlat_cnt_o(xlat_cnt),
    .fault_cnt_o(fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding translation per channel, answered
  // LAT cycles after the cycle in which it was accepted.
  bit            m_known = 1'b0;
  bit            m_busy  [NC];
  int            m_due   [NC];
  logic [PA-1:0] m_paddr [NC];
  bit            m_fault [NC];
  int            m_xlat  = 0;
  int            m_fcnt  = 0;
  int            cyc     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic void ref_xlat(input logic [VA-1:0] va, output logic [PA-1:0] pa, output bit f);
    logic [PA:0] sum;
    f  = 1'b0;
    pa = PA'(va);
    if (mode == 2'b01) begin
      sum = {1'b0, PA'(va)} + {1'b0, offset};
      pa  = sum[PA-1:0];
    end else if (mode == 2'b10 && ((va ^ fbase) & fmask) == '0) begin
      f  = 1'b1;
      pa = '0;
    end
  endfunction

  // Compare the current cycle against the model, advance the model, then step one clock
  task automatic tick();
    bit            ev [NC];
    bit            er;
    bit            any_busy;
    logic [PA-1:0] pa;
    bit            f;
    #1;
    any_busy = 1'b0;
    for (int ch = 0; ch < NC; ch++) begin
      ev[ch]   = m_known && m_busy[ch] && (cyc >= m_due[ch]);
      er       = !m_busy[ch] && !flush && !rst;
      any_busy = any_busy | m_busy[ch];
      check($sformatf("req_ready[%0d]", ch), req_ready[ch], er);
      if (m_known) begin
        check($sformatf("rsp_valid[%0d]", ch), rsp_valid[ch], ev[ch]);
        if (ev[ch]) begin
          check($sformatf("rsp_paddr[%0d]", ch), rsp_paddr[ch*PA +: PA], m_paddr[ch]);
          check($sformatf("rsp_fault[%0d]", ch), rsp_fault[ch], m_fault[ch]);
        end
      end
    end
    if (m_known) begin
      check("busy", busy, any_busy);
      check("xlat_cnt", xlat_cnt, m_xlat);
      check("fault_cnt", fault_cnt, m_fcnt);
    end
    if (rst) begin
      for (int ch = 0; ch < NC; ch++) m_busy[ch] = 1'b0;
      m_xlat  = 0;
      m_fcnt  = 0;
      m_known = 1'b1;
    end else begin
      for (int ch = 0; ch < NC; ch++) begin
        if (ev[ch] && rsp_ready[ch]) begin
          if (m_xlat < MAX) m_xlat++;
          if (m_fault[ch] && m_fcnt < MAX) m_fcnt++;
          m_busy[ch] = 1'b0;
        end else if (!m_busy[ch] && !flush && req_valid[ch]) begin
          ref_xlat(req_vaddr[ch*VA +: VA], pa, f);
          m_busy[ch]  = 1'b1;
          m_due[ch]   = cyc + LAT;
          m_paddr[ch] = pa;
          m_fault[ch] = f;
        end
      end
      if (flush) for (int ch = 0; ch < NC; ch++) m_busy[ch] = 1'b0;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    rst = 1'b0; flush = 1'b0; mode = 2'b00; offset = '0; fbase = '0; fmask = '0;
    req_valid = '0; req_vaddr = '0; rsp_ready = '0;
  endtask

  task automatic random_inputs();
    rst    = ($urandom_range(199) == 0);
    flush  = ($urandom_range(29) == 0);
    mode   = 2'($urandom_range(3));
    offset = ($urandom_range(7) == 0) ? {PA{1'b1}} : PA'({$urandom, $urandom});
    fbase  = VA'({$urandom, $urandom});
    case ($urandom_range(3))
      0:       fmask = '0;
      1:       fmask = VA'({$urandom, $urandom});
      default: fmask = VA'({$urandom, $urandom}) & VA'({$urandom, $urandom}) & VA'({$urandom, $urandom});
    endcase
    for (int ch = 0; ch < NC; ch++) begin
      req_valid[ch] = 1'($urandom_range(1));
      if ($urandom_range(1) == 0) req_vaddr[ch*VA +: VA] = fbase ^ VA'($urandom_range(255));
      else                        req_vaddr[ch*VA +: VA] = VA'({$urandom, $urandom});
      rsp_ready[ch] = ($urandom_range(3) != 0);
    end
  endtask

  initial begin
    quiet_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_xlat_cnt", xlat_cnt, 0);
    check("reset_busy", busy, 0);

    // Identity, accepted in cycle t, response visible in cycle t+3
    req_valid = 2'b01;
    req_vaddr[0 +: VA] = VA'(64'h8000_1000);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("t1_valid", rsp_valid[0], 1);
    check("t1_paddr", rsp_paddr[0 +: PA], 64'h8000_1000);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    check("t1_xlat_cnt", xlat_cnt, 1);

    // Offset mode wraps modulo 2^56
    mode = 2'b01; offset = {PA{1'b1}};
    req_valid = 2'b10;
    req_vaddr[VA +: VA] = VA'(2);
    tick();
    req_valid = '0; mode = 2'b00; offset = '0;
    tick();
    tick();
    check("t2_paddr", rsp_paddr[PA +: PA], 64'h1);
    rsp_ready = 2'b10;
    tick();

    // Fault window, one faulting and one passing address
    mode = 2'b10; fbase = VA'(64'h4000_0000); fmask = VA'(64'h7FFF_F000);
    req_valid = 2'b11;
    req_vaddr[0 +: VA]  = VA'(64'h4000_0ABC);
    req_vaddr[VA +: VA] = VA'(64'h4000_1000);
    rsp_ready = '0;
    tick();
    req_valid = '0; mode = 2'b00;
    tick();
    tick();
    check("t3_fault0", rsp_fault[0], 1);
    check("t3_paddr0", rsp_paddr[0 +: PA], 0);
    check("t3_fault1", rsp_fault[1], 0);
    check("t3_paddr1", rsp_paddr[PA +: PA], 64'h4000_1000);
    rsp_ready = 2'b11;
    tick();
    check("t3_fault_cnt", fault_cnt, 1);
    check("t3_xlat_cnt", xlat_cnt, 4);

    // Backpressure with a new request held waiting
    rsp_ready = '0;
    req_valid = 2'b01;
    req_vaddr[0 +: VA] = VA'(64'h1234_5678);
    for (int i = 0; i < LAT + 5; i++) tick();
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    req_valid = '0;
    tick();

    // Flush mid-WAIT on both channels, with requests held during flush
    req_valid = 2'b11;
    tick();
    req_valid = '0;
    tick();
    flush = 1'b1; req_valid = 2'b11;
    tick();
    flush = 1'b0; req_valid = '0;
    check("t5_flush_busy", busy, 0);
    tick();

    // Reset mid-WAIT on both channels
    req_valid = 2'b11;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", busy, 0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      tick();
    end

    // Saturation: both channels in lockstep from zero, reaching MAX-1 together
    quiet_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 2'b10; fmask = '0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 1300; i++) tick();
    check("t6_xlat_sat", xlat_cnt, MAX);
    check("t6_fault_sat", fault_cnt, MAX);
    quiet_inputs();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
